// File: rtl/front_panel_switch_reader_pkg.sv
// front_panel_pkg: shared types and constants for the Altair front-panel
// switch reader.
//   - SWITCHES_TOTAL_NUMBER / LEDS_TOTAL_NUMBER: panel geometry
//   - sw_status_t and the SW_* encodings (bit1 = up closed, bit0 = down closed)
//   - fsm_state_t: scan sequencer states
//   - decode_pair(): raw active-low contact pair -> sw_status_t
package front_panel_pkg;

  localparam int unsigned SWITCHES_TOTAL_NUMBER = 25;
  localparam int unsigned LEDS_TOTAL_NUMBER     = 36;

  typedef logic [1:0] sw_status_t;

  localparam sw_status_t SW_OFF   = 2'b00;
  localparam sw_status_t SW_DOWN  = 2'b01;
  localparam sw_status_t SW_UP    = 2'b10;
  localparam sw_status_t SW_FAULT = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_COMMIT
  } fsm_state_t;

  // Contacts pull the chain input low when closed.
  function automatic sw_status_t decode_pair(input logic up_raw, input logic dn_raw);
    return {~up_raw, ~dn_raw};
  endfunction

endpackage

// File: rtl/front_panel_switch_reader_debounce_cell.sv
// switch_debounce_cell: per-switch debounce counter and hold register.
//   clk, reset : system clock, synchronous active-high reset
//   commit_i   : one-cycle strobe when cand_i holds a fresh scan result
//   cand_i     : candidate status decoded from the latest scan
//   status_o   : accepted (debounced) status
// A change is accepted on the DEBOUNCE_SCANS-th consecutive identical
// candidate that differs from status_o. A fault candidate (both contacts
// closed) holds the output and clears the count.
module switch_debounce_cell
  import front_panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       commit_i,
  input  sw_status_t cand_i,
  output sw_status_t status_o
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] run_cnt;
  sw_status_t       status_q, status_d;
  sw_status_t       prev_q, prev_d;

  // A candidate that differs from the last scan's candidate starts a new run.
  assign run_cnt = (cand_i != prev_q) ? '0 : cnt_q;

  always_comb begin
    cnt_d    = cnt_q;
    status_d = status_q;
    prev_d   = prev_q;
    if (commit_i) begin
      prev_d = cand_i;
      if (cand_i == SW_FAULT || cand_i == status_q) begin
        cnt_d = '0;
      end else if (run_cnt == CNT_LAST) begin
        status_d = cand_i;
        cnt_d    = '0;
      end else begin
        cnt_d = run_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      status_q <= SW_OFF;
      prev_q   <= SW_OFF;
    end else begin
      cnt_q    <= cnt_d;
      status_q <= status_d;
      prev_q   <= prev_d;
    end
  end

  assign status_o = status_q;

endmodule

// File: rtl/front_panel_switch_reader.sv
// front_panel_switch_reader: scans the front-panel switches through a
// 74HC165-style PISO chain and publishes a 2-bit status per switch.
//   clk, reset      : system clock, synchronous active-high reset
//   sr_load_n       : parallel-load strobe to the chain (active-low)
//   sr_clk          : shift clock to the chain
//   sr_data         : serial data from the chain's last stage (active-low contacts)
//   switches_status : per-switch status, bit1 = up closed, bit0 = down closed
//   scan_done       : one-cycle pulse, same cycle the new status is visible
// Optional build macro FRONT_PANEL_DEBOUNCE_EN adds per-switch debouncing
// (switch_debounce_cell); without it every valid scan result is copied out.
module front_panel_switch_reader
  import front_panel_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 8,
  parameter int unsigned SCAN_INTERVAL  = 50000,
  parameter int unsigned SWITCH_COUNT   = SWITCHES_TOTAL_NUMBER,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       sr_load_n,
  output logic       sr_clk,
  input  logic       sr_data,
  output sw_status_t switches_status [0:SWITCH_COUNT-1],
  output logic       scan_done
);

  if (CLK_DIV < 1 || SCAN_INTERVAL < 1 || SWITCH_COUNT < 1 || DEBOUNCE_SCANS < 1) begin : g_bad_cfg
    $error("front_panel_switch_reader: parameters must all be >= 1");
  end

  localparam int unsigned BITS  = 2 * SWITCH_COUNT;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned INT_W = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;
  localparam int unsigned BIT_W = $clog2(BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(SCAN_INTERVAL - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);

  fsm_state_t       state_q;
  logic [INT_W-1:0] int_cnt_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [BITS-1:0]  capture_q;
  logic             sr_load_n_q;
  logic             sr_clk_q;
  logic             scan_done_q;

  logic             commit;
  sw_status_t       cand   [0:SWITCH_COUNT-1];
  sw_status_t       status_q [0:SWITCH_COUNT-1];

  // Scan sequencer; the strobes are registered alongside the state so
  // they change exactly on state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT;
      int_cnt_q   <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sr_load_n_q <= 1'b1;
      sr_clk_q    <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      unique case (state_q)
        ST_WAIT: begin
          if (int_cnt_q == INT_LAST) begin
            int_cnt_q   <= '0;
            sr_load_n_q <= 1'b0;
            state_q     <= ST_LOAD;
          end else begin
            int_cnt_q <= int_cnt_q + 1'b1;
          end
        end
        ST_LOAD: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q   <= '0;
            sr_load_n_q <= 1'b1;
            state_q     <= ST_SHIFT_LO;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        ST_SHIFT_LO: begin
          if (div_cnt_q == DIV_LAST) begin
            // Sample at the end of the low phase, just before the rising
            // edge advances the chain.
            div_cnt_q            <= '0;
            capture_q[bit_cnt_q] <= sr_data;
            sr_clk_q             <= 1'b1;
            state_q              <= ST_SHIFT_HI;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            sr_clk_q  <= 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_COMMIT;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              state_q   <= ST_SHIFT_LO;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          scan_done_q <= 1'b1;
          state_q     <= ST_WAIT;
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign commit = (state_q == ST_COMMIT);

  always_comb begin
    for (int unsigned i = 0; i < SWITCH_COUNT; i++) begin
      cand[i] = decode_pair(capture_q[2*i], capture_q[2*i+1]);
    end
  end

`ifdef FRONT_PANEL_DEBOUNCE_EN
  for (genvar g = 0; g < SWITCH_COUNT; g++) begin : g_debounce
    switch_debounce_cell #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .commit_i (commit),
      .cand_i   (cand[g]),
      .status_o (status_q[g])
    );
  end
`else
  sw_status_t status_d [0:SWITCH_COUNT-1];

  always_comb begin
    status_d = status_q;
    if (commit) begin
      for (int unsigned i = 0; i < SWITCH_COUNT; i++) begin
        if (cand[i] != SW_FAULT) begin
          status_d[i] = cand[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '{default: SW_OFF};
    end else begin
      status_q <= status_d;
    end
  end
`endif

  assign sr_load_n       = sr_load_n_q;
  assign sr_clk          = sr_clk_q;
  assign scan_done       = scan_done_q;
  assign switches_status = status_q;

endmodule

// File: tb/tb_front_panel_switch_reader.sv
// Self-checking bench for front_panel_switch_reader with a behavioural
// 74HC165 chain and a per-scan scoreboard of expected switch status.
module tb_front_panel_switch_reader;
  import front_panel_pkg::*;

  localparam int unsigned CD  = 3;
  localparam int unsigned SI  = 10;
  localparam int unsigned NSW = 25;
  localparam int unsigned DS  = 4;
  localparam int unsigned NB  = 2 * NSW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sr_load_n, sr_clk, sr_data, scan_done;
  sw_status_t switches_status [0:NSW-1];

  always #5 clk = ~clk;

  front_panel_switch_reader #(
    .CLK_DIV        (CD),
    .SCAN_INTERVAL  (SI),
    .SWITCH_COUNT   (NSW),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sr_load_n       (sr_load_n),
    .sr_clk          (sr_clk),
    .sr_data         (sr_data),
    .switches_status (switches_status),
    .scan_done       (scan_done)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pack_st(input sw_status_t a [NSW]);
    logic [63:0] v = '0;
    for (int i = 0; i < NSW; i++) v[2*i +: 2] = a[i];
    return v;
  endfunction

  // Physical switch positions presented to the chain at the next load.
  sw_status_t pat [NSW];

  function automatic logic [NB-1:0] encode_chain();
    logic [NB-1:0] v;
    for (int i = 0; i < NSW; i++) begin
      v[2*i]   = ~pat[i][1];
      v[2*i+1] = ~pat[i][0];
    end
    return v;
  endfunction

  logic [NB-1:0] chain = '1;
  always @(negedge sr_load_n or posedge sr_clk) begin
    if (!sr_load_n) chain <= encode_chain();
    else            chain <= {1'b1, chain[NB-1:1]};
  end
  assign sr_data = chain[0];

  // Reference model of the published status.
  sw_status_t  m_stat [NSW];
  sw_status_t  m_prev [NSW];
  int          m_run  [NSW];
  logic [63:0] exp_q  [$];

  task automatic model_reset();
    for (int i = 0; i < NSW; i++) begin
      m_stat[i] = SW_OFF;
      m_prev[i] = SW_OFF;
      m_run[i]  = 0;
    end
  endtask

  task automatic expect_scan();
    for (int i = 0; i < NSW; i++) begin
      sw_status_t c;
      c = pat[i];
`ifdef FRONT_PANEL_DEBOUNCE_EN
      if (c == SW_FAULT || c == m_stat[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i] = (c == m_prev[i]) ? m_run[i] + 1 : 1;
        if (m_run[i] >= int'(DS)) begin
          m_stat[i] = c;
          m_run[i]  = 0;
        end
      end
      m_prev[i] = c;
`else
      if (c != SW_FAULT) m_stat[i] = c;
`endif
    end
    exp_q.push_back(pack_st(m_stat));
  endtask

  // Output monitor: scoreboard pop, strobe widths, update timing.
  int          done_cnt = 0;
  int          rises = 0, ld_len = 0, lo_len = 0, hi_len = 0;
  bit          skip = 1'b1;
  logic        prev_done = 1'b0, prev_ld = 1'b1, prev_clk = 1'b0;
  logic [63:0] last_pack = '0;

  always @(negedge clk) begin
    logic [63:0] cur;
    cur = pack_st(switches_status);
    if (reset) begin
      skip   = 1'b1;
      ld_len = 0;
      lo_len = 0;
      hi_len = 0;
    end else begin
      if (cur !== last_pack) check_eq("status_only_with_done", scan_done, 1);
      if (scan_done) begin
        check_eq("done_width", prev_done, 0);
        check_eq("sr_clk_rises", rises, NB);
        check_eq("sb_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) check_eq("status", cur, exp_q.pop_front());
        done_cnt++;
      end
      if (!sr_load_n) begin
        if (prev_ld) begin
          ld_len = 0;
          rises  = 0;
        end
        ld_len++;
        lo_len = 0;
        skip   = 1'b0;
      end else if (!prev_ld && !skip) begin
        check_eq("load_low_width", ld_len, CD);
      end
      if (sr_clk) begin
        if (!prev_clk) begin
          rises++;
          if (!skip) check_eq("sr_clk_low_width", lo_len, CD);
          hi_len = 0;
        end
        hi_len++;
      end else begin
        if (prev_clk) begin
          if (!skip) check_eq("sr_clk_high_width", hi_len, CD);
          lo_len = 0;
        end
        if (sr_load_n) lo_len++;
      end
    end
    last_pack = cur;
    prev_done = scan_done;
    prev_ld   = sr_load_n;
    prev_clk  = sr_clk;
  end

  task automatic check_reset_values();
    check_eq("rst_status", pack_st(switches_status), 0);
    check_eq("rst_load_n", sr_load_n, 1);
    check_eq("rst_sr_clk", sr_clk, 0);
    check_eq("rst_done", scan_done, 0);
  endtask

  // Called #1 after a posedge with reset high; releases reset and times
  // the first load.
  task automatic release_and_time_load();
    int cycles = 0;
    reset = 1'b0;
    while (sr_load_n && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_eq("load_delay_after_reset", cycles, SI);
  endtask

  task automatic wait_scan();
    int start = done_cnt;
    int t = 0;
    while (done_cnt == start && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("scan_completed", done_cnt != start, 1);
  endtask

  task automatic set_all(input sw_status_t v);
    for (int i = 0; i < NSW; i++) pat[i] = v;
  endtask

  task automatic do_scan();
    expect_scan();
    wait_scan();
  endtask

  initial begin
    set_all(SW_OFF);
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_reset_values();

    // Switch 3 up, switch 20 down.
    pat[3]  = SW_UP;
    pat[20] = SW_DOWN;
    expect_scan();
    release_and_time_load();
    wait_scan();
`ifndef FRONT_PANEL_DEBOUNCE_EN
    check_eq("sw3_up", switches_status[3], SW_UP);
    check_eq("sw20_down", switches_status[20], SW_DOWN);
`endif

    // Switch 7 up, then a both-closed fault reading.
    pat[7] = SW_UP;
    do_scan();
    pat[7] = SW_FAULT;
    do_scan();
`ifndef FRONT_PANEL_DEBOUNCE_EN
    check_eq("sw7_fault_hold", switches_status[7], SW_UP);
`endif

    // Random positions, faults included; some repeated to let debounce settle.
    for (int s = 0; s < 8; s++) begin
      if (s % 3 == 0) begin
        for (int i = 0; i < NSW; i++) pat[i] = sw_status_t'($urandom_range(0, 3));
      end
      do_scan();
    end

    // Reset in the middle of the shift phase abandons the scan.
    begin
      int t = 0;
      while (!sr_clk && t < 1000) begin
        @(negedge clk);
        t++;
      end
      check_eq("reached_shift", sr_clk, 1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_values();
    exp_q.delete();
    model_reset();

`ifdef FRONT_PANEL_DEBOUNCE_EN
    // Alternating up/open never accumulates enough to be accepted.
    set_all(SW_OFF);
    pat[0] = SW_UP;
    expect_scan();
    release_and_time_load();
    wait_scan();
    check_eq("alt_scan0", switches_status[0], SW_OFF);
    for (int s = 1; s < 6; s++) begin
      pat[0] = (s % 2 == 1) ? SW_OFF : SW_UP;
      do_scan();
      check_eq("alt_hold", switches_status[0], SW_OFF);
    end
    // Steady up: accepted on the 4th scan, not the 3rd.
    pat[0] = SW_UP;
    for (int s = 1; s <= int'(DS); s++) begin
      do_scan();
      if (s == int'(DS) - 1) check_eq("deb_before_accept", switches_status[0], SW_OFF);
      if (s == int'(DS))     check_eq("deb_accept", switches_status[0], SW_UP);
    end
`else
    set_all(SW_OFF);
    pat[12] = SW_DOWN;
    expect_scan();
    release_and_time_load();
    wait_scan();
    check_eq("post_reset_sw12", switches_status[12], SW_DOWN);
    check_eq("post_reset_sw7", switches_status[7], SW_OFF);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
